// File: rtl/sample_feeder8.sv
// Sample feeder for the 8-PE systolic Chebyshev interpolator: buffers acquisition
// words and presents one word per slot of pe_timing+1 cycles to the PE chain.
module sample_feeder8 #(
  parameter int          WORDLENGTH     = 16,
  parameter int          FIFO_DEPTH     = 16,
  parameter int          ADDR_W         = 4,
  parameter logic [31:0] DEFAULT_TIMING = 32'd40
) (
  input  logic                  clk30x,
  input  logic                  reset,
  input  logic [WORDLENGTH-1:0] in_word,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           cfg_timing,
  input  logic                  cfg_load,
  output logic [WORDLENGTH-1:0] pe_word,
  output logic [31:0]           pe_timing,
  output logic [2:0]            slot_index,
  output logic                  slot_start,
  output logic                  frame_done,
  output logic                  underrun,
  output logic [ADDR_W:0]       fifo_level
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(FIFO_DEPTH);

  state_t                state_q, state_d;
  logic [WORDLENGTH-1:0] mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]       level_q, level_d;
  logic [31:0]           slot_cnt_q, slot_cnt_d;
  logic [31:0]           timing_q, timing_d;
  logic [2:0]            index_q, index_d;
  logic [WORDLENGTH-1:0] word_q;
  logic                  start_q, start_d;
  logic                  frame_q, frame_d;
  logic                  under_q, under_d;
  logic                  push, pop, zero_fill, fifo_empty;

  assign fifo_empty = (level_q == '0);
  assign in_ready   = !reset && (level_q < DEPTH_L);
  assign push       = in_valid && in_ready;

  // Storage array has no reset so it maps onto block RAM.
  always_ff @(posedge clk30x) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_word;
    end
  end

  always_ff @(posedge clk30x) begin
    if (reset) begin
      word_q <= '0;
    end else if (pop) begin
      word_q <= mem_q[rd_ptr_q];
    end else if (zero_fill) begin
      word_q <= '0;
    end
  end

  // Pop decisions use the registered level, so a word written this edge
  // cannot be read out before the next one.
  always_comb begin
    state_d    = state_q;
    slot_cnt_d = slot_cnt_q;
    timing_d   = timing_q;
    index_d    = index_q;
    start_d    = 1'b0;
    frame_d    = 1'b0;
    under_d    = 1'b0;
    pop        = 1'b0;
    zero_fill  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_load) begin
          timing_d = cfg_timing;
        end
        if (!fifo_empty) begin
          pop        = 1'b1;
          slot_cnt_d = '0;
          index_d    = 3'd0;
          start_d    = 1'b1;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        if (slot_cnt_q == timing_q) begin
          slot_cnt_d = '0;
          index_d    = index_q + 3'd1;
          start_d    = 1'b1;
          frame_d    = (index_q == 3'd7);
          if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            zero_fill = 1'b1;
            under_d   = 1'b1;
          end
        end else begin
          slot_cnt_d = slot_cnt_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk30x) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      slot_cnt_q <= '0;
      timing_q   <= DEFAULT_TIMING;
      index_q    <= 3'd0;
      start_q    <= 1'b0;
      frame_q    <= 1'b0;
      under_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      slot_cnt_q <= slot_cnt_d;
      timing_q   <= timing_d;
      index_q    <= index_d;
      start_q    <= start_d;
      frame_q    <= frame_d;
      under_q    <= under_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  assign pe_word    = word_q;
  assign pe_timing  = timing_q;
  assign slot_index = index_q;
  assign slot_start = start_q;
  assign frame_done = frame_q;
  assign underrun   = under_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_sample_feeder8.sv
// Randomised bench for sample_feeder8: a queue-based slot model feeds a scoreboard
// that a negedge monitor drains on every slot_start.
module tb_sample_feeder8;

  logic        clk30x = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in_word = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] cfg_timing = '0;
  logic        cfg_load = 1'b0;
  logic [15:0] pe_word;
  logic [31:0] pe_timing;
  logic [2:0]  slot_index;
  logic        slot_start, frame_done, underrun;
  logic [4:0]  fifo_level;

  always #5 clk30x = ~clk30x;

  sample_feeder8 dut (
    .clk30x     (clk30x),
    .reset      (reset),
    .in_word    (in_word),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .cfg_timing (cfg_timing),
    .cfg_load   (cfg_load),
    .pe_word    (pe_word),
    .pe_timing  (pe_timing),
    .slot_index (slot_index),
    .slot_start (slot_start),
    .frame_done (frame_done),
    .underrun   (underrun),
    .fifo_level (fifo_level)
  );

  typedef struct {
    logic [15:0] word;
    int          idx;
    bit          fd;
    bit          ur;
    logic [31:0] timing;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mq[$];
  bit          m_run = 0;
  int          m_age = 0;
  int          m_slot_no = 0;
  logic [31:0] m_timing = 32'd40;
  logic [15:0] m_word = '0;
  bit          m_start = 0;
  bit          started = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
  endtask

  // Behavioural model: a word queue, a slot age counter and a running slot number.
  always @(posedge clk30x) begin
    int lvl;
    bit acc;
    bit boundary;
    started  = 1;
    m_start  = 0;
    boundary = 0;
    if (reset) begin
      mq.delete();
      exp_q.delete();
      m_run     = 0;
      m_age     = 0;
      m_slot_no = 0;
      m_timing  = 32'd40;
      m_word    = '0;
    end else begin
      lvl = mq.size();
      acc = in_valid && (lvl < 16);
      if (!m_run) begin
        if (cfg_load) m_timing = cfg_timing;
        if (lvl > 0) begin
          m_run     = 1;
          m_age     = 0;
          m_slot_no = 0;
          boundary  = 1;
        end
      end else if (m_age == int'(m_timing)) begin
        m_age = 0;
        m_slot_no++;
        boundary = 1;
      end else begin
        m_age++;
      end
      if (boundary) begin
        exp_t e;
        m_start = 1;
        e.ur = 0;
        if (mq.size() > 0) m_word = mq.pop_front();
        else begin
          m_word = '0;
          e.ur = 1;
        end
        e.word   = m_word;
        e.idx    = m_slot_no % 8;
        e.fd     = (m_slot_no > 0) && (m_slot_no % 8 == 0);
        e.timing = m_timing;
        exp_q.push_back(e);
      end
      if (acc) mq.push_back(in_word);
    end
  end

  always @(negedge clk30x) begin
    if (started) begin
      check("in_ready", in_ready, (!reset && mq.size() < 16));
      check("fifo_level", fifo_level, mq.size());
      check("slot_start", slot_start, m_start);
      check("pe_word_hold", pe_word, m_word);
      check("pe_timing", pe_timing, m_timing);
      check("slot_index", slot_index, m_slot_no % 8);
      if (slot_start) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_underflow: got slot_start with no expected slot at %0t", $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_word", pe_word, e.word);
          check("sb_index", slot_index, e.idx);
          check("sb_frame_done", frame_done, e.fd);
          check("sb_underrun", underrun, e.ur);
          check("sb_timing", pe_timing, e.timing);
        end
      end else begin
        check("frame_done_quiet", frame_done, 0);
        check("underrun_quiet", underrun, 0);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk30x);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
  endtask

  task automatic load_timing(input logic [31:0] t);
    cfg_timing = t;
    cfg_load   = 1'b1;
    cycles(1);
    cfg_load   = 1'b0;
  endtask

  task automatic push_word(input logic [15:0] w);
    int   guard;
    logic ready_s;
    guard    = 0;
    in_word  = w;
    in_valid = 1'b1;
    forever begin
      @(negedge clk30x);
      ready_s = in_ready;
      @(posedge clk30x);
      #1;
      if (ready_s) break;
      guard++;
      if (guard > 5000) begin
        n_checks++;
        $display("FAIL push_timeout: in_ready stuck low at %0t", $time);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    cycles(3);
    reset = 1'b0;

    // 4-cycle slots, eight words then a zero-insertion frame wrap
    load_timing(32'd3);
    for (int i = 1; i <= 8; i++) push_word(16'(i));
    cycles(50);

    // default 41-cycle slots with a single word then underruns
    do_reset();
    push_word(16'($urandom));
    cycles(150);

    // long slots: FIFO fills and the source is held off until a boundary pop
    do_reset();
    load_timing(32'd1000);
    for (int i = 0; i < 18; i++) push_word(16'($urandom));
    cycles(20);

    // 1-cycle slots with pointer wrap
    do_reset();
    load_timing(32'd0);
    for (int i = 0; i < 40; i++) begin
      push_word(16'($urandom));
      cycles($urandom_range(0, 1));
    end
    cycles(10);

    // 3-cycle slots with bursts, then cfg_load attempted while running
    do_reset();
    load_timing(32'd2);
    for (int i = 0; i < 30; i++) begin
      push_word(16'($urandom));
      if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 2));
    end
    cfg_timing = 32'd7;
    cfg_load   = 1'b1;
    cycles(3);
    cfg_load   = 1'b0;
    cycles(40);

    // reset mid-slot with words buffered, then restart
    do_reset();
    for (int i = 0; i < 7; i++) push_word(16'($urandom));
    cycles(13);
    do_reset();
    push_word(16'($urandom));
    cycles(60);

    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
